apb_wdt: RTL
============

# apb_wdt

APB watchdog timer on a spare APB slave slot of the Godson MCU (apb6/apb7 class), clocked from the 8 MHz PLL clock like the other peripherals. It counts down from a software-loaded value, raises an interrupt toward the interrupt controller on first expiry, and, if software still has not fed it, pulses a reset request toward the system reset logic. Register writes are guarded by an unlock key.

## Interface
Parameters:
- PRESCALE, 7999: tick period minus 1 in apb_pclk cycles (1 ms at 8 MHz).
- DEFAULT_LOAD, 32'd5000: reset value of LOAD and of the counter.
- RST_PULSE, 16: width of wdt_rst_req in apb_pclk cycles.

Ports:
- apb_pclk, in, 1: the only clock.
- apb_prst, in, 1: reset, asynchronous, active-high.
- apb_psel, in, 1: APB select.
- apb_paddr, in, 5: byte address; bits [4:2] decoded, bits [1:0] ignored.
- apb_pwrite, in, 1: APB write.
- apb_penable, in, 1: APB access phase.
- apb_pwdata, in, 32: write data.
- apb_prdata, out, 32: read data.
- wdt_int, out, 1: level interrupt, equal to pend & INT_EN.
- wdt_rst_req, out, 1: reset request pulse.

## Operation
- Zero-wait APB slave. The system drives ack = penable.
- A write commits on the apb_pclk edge where psel & penable & pwrite.
- apb_prdata is combinational from apb_paddr when psel & !pwrite, and 0 otherwise.
- Register map:
  - 0x00 CTRL: [0] EN, [1] INT_EN, [2] RST_EN. Reset value 0. Writes are ignored while locked.
  - 0x04 LOAD, 32 bits. Reset value DEFAULT_LOAD. Writes are ignored while locked.
  - 0x08 FEED, write-only key. Writing 0x5A5AA5A5 reloads the counter from LOAD, clears the prescaler and returns WARN to RUN. Other values are ignored. Reads return the live counter.
  - 0x0C STAT: [0] pend (write 1 to clear), [1] locked (RO), [3:2] state (RO).
  - 0x10 LOCK: writing 0x1ACCE551 clears locked; any other value sets it. Reads return {31'b0, locked}. locked resets to 1.
  - Reads of any other address return 0.
- Prescaler:
  - Counts 0..PRESCALE while state is RUN or WARN.
  - tick is asserted for one cycle at PRESCALE, then the prescaler wraps to 0.
- Counter:
  - Decrements on tick.
  - Expiry is a tick while the counter is 0 or 1. LOAD=0 therefore expires on the first tick.
- State machine (encoding IDLE=0, RUN=1, WARN=2, RST=3):
  - IDLE → RUN when EN is set. The counter loads from LOAD and the prescaler clears.
  - RUN → WARN on expiry. pend is set and the counter reloads from LOAD.
  - WARN → RUN on a valid FEED.
  - WARN → RST on expiry if RST_EN=1.
  - WARN on expiry with RST_EN=0: stay in WARN, reload the counter, keep pend set.
  - RST: wdt_rst_req=1 for RST_PULSE cycles, then → IDLE with EN cleared.
  - From RUN or WARN, clearing EN → IDLE: the counter is reloaded and the prescaler cleared; pend is kept.
- Simultaneous events:
  - A valid FEED in the same cycle as an expiry wins: reload happens, and pend/RST do not occur.
  - A pend write-1-to-clear in the same cycle as a set: the set wins.
  - LOAD written while running takes effect at the next reload.
- In RST, APB writes to CTRL and FEED are ignored.

## Timing
- All outputs reset to 0 (wdt_int, wdt_rst_req, apb_prdata).
- Internal reset values: state=IDLE, counter=DEFAULT_LOAD, prescaler=0, pend=0, locked=1.
- Latency:
  - wdt_int rises on the cycle after the expiry edge (it is registered through pend).
  - wdt_rst_req rises on the cycle after the entry edge into RST and stays high exactly RST_PULSE cycles.
- Time from EN=1 to first expiry: (LOAD)·(PRESCALE+1) cycles, counting from the write edge.
- Asserting apb_prst mid-pulse drops wdt_rst_req immediately (asynchronous) and all state returns to reset values.

## Structure
- Shared package apb_wdt_pkg holds:
  - register offsets;
  - FEED_KEY=32'h5A5AA5A5 and UNLOCK_KEY=32'h1ACCE551;
  - state encodings;
  - CTRL bit indices.
- One sub-module, wdt_prescaler: counter plus tick generator, parameterised by PRESCALE, with a clear input.
- Register file, FSM and counter live in apb_wdt. Expected size is about 200 lines.

## Test plan
- Reset, then read all registers → CTRL=0, LOAD=5000, STAT=0x2, LOCK=1. Write CTRL=1 while locked → CTRL still reads 0.
- PRESCALE=3, unlock, LOAD=4, CTRL=0x3 → wdt_int rises 16 cycles after the CTRL write. STAT reads 0x9 (pend, WARN). Write STAT=1 → wdt_int falls.
- Same configuration, feed with 0x5A5AA5A5 every 12 cycles for 100 cycles → wdt_int is never asserted. Feed with 0x12345678 → ignored, expiry occurs.
- PRESCALE=3, LOAD=2, CTRL=0x7, no feed → pend at about 8 cycles. wdt_rst_req is high for exactly 16 cycles at about 16 cycles. Afterwards CTRL.EN=0 and state=IDLE.
- Valid FEED issued on the exact expiry cycle in WARN → no wdt_rst_req, state reads RUN.
- Assert apb_prst during the wdt_rst_req pulse → the pulse ends in the same cycle and registers return to reset values.

Source files
------------

// File: rtl/apb_wdt_pkg.sv
// Shared definitions for the APB watchdog: register word offsets, access keys,
// FSM state encoding and CTRL bit positions.
package apb_wdt_pkg;

  // Word offsets, decoded from apb_paddr[4:2]
  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_LOAD = 3'd1;
  localparam logic [2:0] ADDR_FEED = 3'd2;
  localparam logic [2:0] ADDR_STAT = 3'd3;
  localparam logic [2:0] ADDR_LOCK = 3'd4;

  localparam logic [31:0] FEED_KEY   = 32'h5A5A_A5A5;
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_INT_EN = 1;
  localparam int unsigned CTRL_RST_EN = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWarn = 2'd2,
    StRst  = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/wdt_prescaler.sv
// Free-running 0..PRESCALE divider producing a one-cycle tick at the top count.
module wdt_prescaler #(
  parameter int unsigned PRESCALE = 7999
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic          at_top;

  assign at_top = (cnt_q == CW'(PRESCALE));
  // A clear restarts the period, so the tick in that cycle is dropped
  assign tick_o = run_i & at_top & ~clr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || !run_i || at_top) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/apb_wdt.sv
// APB watchdog: key-guarded registers, countdown counter, warn/reset FSM.
// First expiry raises pend/wdt_int; a second unfed expiry pulses wdt_rst_req.
module apb_wdt
  import apb_wdt_pkg::*;
#(
  parameter int unsigned PRESCALE     = 7999,
  parameter logic [31:0] DEFAULT_LOAD = 32'd5000,
  parameter int unsigned RST_PULSE    = 16
) (
  input  logic        apb_pclk,
  input  logic        apb_prst,
  input  logic        apb_psel,
  input  logic [4:0]  apb_paddr,
  input  logic        apb_pwrite,
  input  logic        apb_penable,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  output logic        wdt_int,
  output logic        wdt_rst_req
);

  localparam int unsigned PW = $clog2(RST_PULSE + 1);

  wdt_state_e    state_q;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   load_q;
  logic          locked_q;
  logic [31:0]   cnt_q;
  logic          pend_q;
  logic          rst_req_q;
  logic [PW-1:0] pulse_q;

  logic [2:0] idx;
  logic       wr, wr_ctrl, feed, pend_clr, rst_done;
  logic       running, en_next, presc_clr, tick, expire;
  logic       unused_paddr;

  assign idx          = apb_paddr[4:2];
  assign unused_paddr = ^apb_paddr[1:0];
  assign wr           = apb_psel & apb_penable & apb_pwrite;
  assign wr_ctrl      = wr && (idx == ADDR_CTRL) && !locked_q && (state_q != StRst);
  assign feed         = wr && (idx == ADDR_FEED) && (apb_pwdata == FEED_KEY) &&
                        (state_q != StRst);
  assign pend_clr     = wr && (idx == ADDR_STAT) && apb_pwdata[0];
  assign rst_done     = (state_q == StRst) && (pulse_q == PW'(RST_PULSE - 1));
  assign running      = (state_q == StRun) || (state_q == StWarn);
  assign expire       = tick && (cnt_q <= 32'd1);

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = apb_pwdata[2:0];
    if (rst_done) ctrl_d[CTRL_EN] = 1'b0;
  end

  // FSM reacts to EN on the same edge that writes it, so timing counts from the write
  assign en_next   = ctrl_d[CTRL_EN];
  assign presc_clr = ((state_q == StIdle) && en_next) || (running && (!en_next || feed));

  wdt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i (apb_pclk),
    .rst_i (apb_prst),
    .clr_i (presc_clr),
    .run_i (running),
    .tick_o(tick)
  );

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      ctrl_q   <= '0;
      load_q   <= DEFAULT_LOAD;
      locked_q <= 1'b1;
    end else begin
      ctrl_q <= ctrl_d;
      if (wr && (idx == ADDR_LOAD) && !locked_q) load_q <= apb_pwdata;
      if (wr && (idx == ADDR_LOCK)) locked_q <= (apb_pwdata != UNLOCK_KEY);
    end
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      state_q   <= StIdle;
      cnt_q     <= DEFAULT_LOAD;
      pend_q    <= 1'b0;
      rst_req_q <= 1'b0;
      pulse_q   <= '0;
    end else begin
      // A set later in this block overrides the clear
      pend_q <= pend_q & ~pend_clr;
      unique case (state_q)
        StIdle: begin
          if (en_next) begin
            state_q <= StRun;
            cnt_q   <= load_q;
          end else if (feed) begin
            cnt_q <= load_q;
          end
        end
        StRun, StWarn: begin
          if (!en_next) begin
            state_q <= StIdle;
            cnt_q   <= load_q;
          end else if (feed) begin
            state_q <= StRun;
            cnt_q   <= load_q;
          end else if (expire) begin
            cnt_q  <= load_q;
            pend_q <= 1'b1;
            if ((state_q == StWarn) && ctrl_q[CTRL_RST_EN]) begin
              state_q   <= StRst;
              rst_req_q <= 1'b1;
              pulse_q   <= '0;
            end else begin
              state_q <= StWarn;
            end
          end else if (tick) begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        StRst: begin
          if (rst_done) begin
            state_q   <= StIdle;
            rst_req_q <= 1'b0;
            cnt_q     <= load_q;
          end else begin
            pulse_q <= pulse_q + PW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wdt_int     = pend_q & ctrl_q[CTRL_INT_EN];
  assign wdt_rst_req = rst_req_q;

  always_comb begin
    apb_prdata = '0;
    if (apb_psel && !apb_pwrite) begin
      case (idx)
        ADDR_CTRL: apb_prdata = {29'd0, ctrl_q};
        ADDR_LOAD: apb_prdata = load_q;
        ADDR_FEED: apb_prdata = cnt_q;
        ADDR_STAT: apb_prdata = {28'd0, state_q, locked_q, pend_q};
        ADDR_LOCK: apb_prdata = {31'd0, locked_q};
        default:   apb_prdata = '0;
      endcase
    end
  end

endmodule
